// File: rtl/shift_universal.sv
// Universal shift/rotate register: parallel load, single-step shift, multi-cycle shift-by-N sequencer.
// Latency: every output is a flop; a step taken at an edge is visible in the following cycle.
// No backpressure: start/ena are dropped while busy, load overrides and aborts a running sequence.
module shift_universal #(
    parameter  int WIDTH   = 8,
    parameter  int MAX_AMT = 15,
    localparam int AW      = $clog2(MAX_AMT + 1)
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             load,
    input  logic             ena,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [AW-1:0]    amt,
    input  logic [WIDTH-1:0] data,
    input  logic             sin,
    output logic [WIDTH-1:0] q,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    // Shift modes; 6 and 7 are reserved and act as hold.
    localparam logic [2:0] MODE_HOLD = 3'd0;
    localparam logic [2:0] MODE_SRL  = 3'd1;
    localparam logic [2:0] MODE_SLL  = 3'd2;
    localparam logic [2:0] MODE_ROR  = 3'd3;
    localparam logic [2:0] MODE_ROL  = 3'd4;
    localparam logic [2:0] MODE_SRA  = 3'd5;

    // Sequencer states.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [AW-1:0] AMT_MAX  = AW'(MAX_AMT);
    localparam logic [AW-1:0] CNT_ONE  = AW'(1);
    localparam logic [AW-1:0] CNT_ZERO = '0;

    logic [WIDTH-1:0] q_q, q_d;
    logic             sout_q, sout_d;
    logic             done_q, done_d;
    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    count_q, count_d;
    logic [2:0]       mode_lat_q, mode_lat_d;

    logic [2:0]       step_mode;
    logic             step_shift;
    logic [WIDTH-1:0] step_q;
    logic             step_out;
    logic [AW-1:0]    amt_c;

    // Counts above MAX_AMT are treated as MAX_AMT (only reachable when MAX_AMT+1 is not a power of two).
    always_comb begin
        amt_c = (amt > AMT_MAX) ? AMT_MAX : amt;
    end

    // One shift step of q_q in the active mode: the running sequence uses its latched mode,
    // otherwise the live mode input. step_shift is low for hold/reserved so q and sout stay put.
    always_comb begin
        step_mode  = (state_q == ST_RUN) ? mode_lat_q : mode;
        step_shift = 1'b1;
        step_q     = q_q;
        step_out   = sout_q;
        case (step_mode)
            MODE_SRL: begin
                step_q   = {sin, q_q[WIDTH-1:1]};
                step_out = q_q[0];
            end
            MODE_SLL: begin
                step_q   = {q_q[WIDTH-2:0], sin};
                step_out = q_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_q   = {q_q[0], q_q[WIDTH-1:1]};
                step_out = q_q[0];
            end
            MODE_ROL: begin
                step_q   = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                step_out = q_q[WIDTH-1];
            end
            MODE_SRA: begin
                step_q   = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
                step_out = q_q[0];
            end
            default: begin
                step_shift = 1'b0;
            end
        endcase
    end

    // Next-state selection in priority order: reset > load > start > ena > sequencer step.
    always_comb begin
        q_d        = q_q;
        sout_d     = sout_q;
        done_d     = 1'b0;
        state_d    = state_q;
        count_d    = count_q;
        mode_lat_d = mode_lat_q;

        if (areset) begin
            q_d        = '0;
            sout_d     = 1'b0;
            state_d    = ST_IDLE;
            count_d    = CNT_ZERO;
            mode_lat_d = MODE_HOLD;
        end else if (load) begin
            // Loading mid-sequence abandons it silently (no done pulse).
            q_d     = data;
            state_d = ST_IDLE;
            count_d = CNT_ZERO;
        end else if (state_q == ST_IDLE && start) begin
            mode_lat_d = mode;
            if (amt_c == CNT_ZERO) begin
                // Zero-length request completes immediately.
                done_d = 1'b1;
            end else begin
                // First step happens on the start edge; count holds the steps still to go.
                if (step_shift) begin
                    q_d    = step_q;
                    sout_d = step_out;
                end
                count_d = amt_c - CNT_ONE;
                if (amt_c == CNT_ONE) begin
                    done_d = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
        end else if (state_q == ST_IDLE && ena) begin
            if (step_shift) begin
                q_d    = step_q;
                sout_d = step_out;
            end
        end else if (state_q == ST_RUN) begin
            if (step_shift) begin
                q_d    = step_q;
                sout_d = step_out;
            end
            // The step that consumes the last remaining count ends the sequence.
            if (count_q <= CNT_ONE) begin
                count_d = CNT_ZERO;
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end else begin
                count_d = count_q - CNT_ONE;
            end
        end
    end

    // State registers; reset is folded into the next-state logic above.
    always_ff @(posedge clk) begin
        q_q        <= q_d;
        sout_q     <= sout_d;
        done_q     <= done_d;
        state_q    <= state_d;
        count_q    <= count_d;
        mode_lat_q <= mode_lat_d;
    end

    // Outputs come straight from flops.
    always_comb begin
        q    = q_q;
        sout = sout_q;
        busy = (state_q == ST_RUN);
        done = done_q;
    end

endmodule

// File: doc/shift_universal.md
Name: shift_universal

Overview:
Parametrised successor to the 4-bit load/enable shift register. Holds a WIDTH-bit register with parallel load, single-step shifting in six modes (logical, arithmetic, rotate), serial in/out, and a multi-cycle "shift by N" sequencer with a busy/done handshake. Used as a general-purpose shift/rotate datapath element under a simple controller.

Parameters:
WIDTH, 8, register width in bits (>=2)
MAX_AMT, 15, largest shift count accepted by the sequencer; amt width AW = $clog2(MAX_AMT+1)

Ports:
clk  input  1  rising-edge clock, sole clock domain
areset  input  1  synchronous reset, active-high; sampled on the rising edge of clk
load  input  1  parallel load of data into q
ena  input  1  single-step shift by one position in the current mode
start  input  1  begin a multi-cycle shift of amt positions
mode  input  3  shift mode (see Behaviour)
amt  input  AW  shift count for start; values > MAX_AMT are clamped to MAX_AMT
data  input  WIDTH  parallel load value
sin  input  1  serial fill bit for logical shifts
q  output  WIDTH  register contents
sout  output  1  registered copy of the last bit shifted or rotated out
busy  output  1  sequencer active
done  output  1  one-cycle pulse on sequencer completion

Behaviour:
- Reset: areset high at an edge -> q=0, sout=0, busy=0, done=0, internal count=0, latched mode=0. areset has top priority over all other inputs.
- Priority per edge: areset > load > start (when idle) > ena (when idle) > sequencer step (when busy).
- Modes: 0 hold; 1 SRL (q>>1, MSB<=sin, out=q[0]); 2 SLL (q<<1, LSB<=sin, out=q[WIDTH-1]); 3 ROR (out=q[0]); 4 ROL (out=q[WIDTH-1]); 5 SRA (MSB replicated, out=q[0]); 6, 7 reserved, behave as hold.
- For every shift step in modes 1-5, sout <= out bit in the same edge. In hold or reserved modes, sout and q are unchanged.
- load: q <= data. sout is unchanged. If busy, load aborts the sequence: busy <= 0, count <= 0, and done is not pulsed.
- ena while idle: exactly one step in the current mode; result is visible one cycle later. ena is ignored while busy.
- Sequencer, state IDLE -> RUN -> IDLE:
  - start in IDLE with amt=N>0: mode is latched and count <= N-1. The first step occurs at the start edge itself. busy=1 from the next cycle if N>1.
  - In RUN, one step per edge using the latched mode (mode input ignored); count decrements. On the step with count==0, return to IDLE.
  - busy is high for N-1 cycles after the start edge. The register holds the Nth result in the cycle after the final step edge.
  - done pulses exactly one cycle, in the cycle after the final step edge (for N=1, the cycle after the start edge).
  - start with amt=0: no shift, busy stays 0, done pulses the next cycle.
  - start while busy: ignored.
- sin is sampled on every step edge, including during RUN.
- areset during RUN: immediate return to IDLE with reset values; no done.
- Latency: all outputs are registered, with no combinational input-to-output path.

Test Plan:
1. Reset: hold areset high for one edge with load=1 and data=8'hFF -> q=8'h00, sout=0, busy=0, done=0 (reset beats load).
2. Single step: load 8'hA5, then mode=1, sin=0, ena=1 for one edge -> q=8'h52, sout=1. Then mode=2, sin=1, ena=1 -> q=8'hA5, sout=0.
3. Multi-step rotate: load 8'h81, then start with mode=4, amt=3 -> q=8'h03, 8'h06, 8'h0C on successive edges. busy high for 2 cycles; done high for exactly 1 cycle, coincident with q=8'h0C. The mode input is changed mid-run and is ignored.
4. Arithmetic: load 8'h80, then start with mode=5, amt=2 -> final q=8'hE0, sout=0. Repeat from 8'h7F -> final q=8'h1F, sout=1.
5. Abort: load 8'h01, then start with mode=3, amt=5. Assert load with data=8'h3C on the second RUN cycle -> q=8'h3C, busy=0 on the next cycle, and no done pulse within 8 cycles.
6. Edge cases: start with amt=0 -> done pulses once, q unchanged, busy never high. With MAX_AMT=15, start with amt=15 and mode=3 on 8'h01 -> q=8'h02 and done pulses once. ena while busy -> no extra shift.
